// File: rtl/fpm_seq.sv
// fpm_seq: iterative radix-2 shift-add floating-point multiplier with
// round-to-nearest-even, special-value handling and valid/ready handshakes.
module fpm_seq #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [3:0]   out_flags
);

  localparam int unsigned P     = MAN_W + 1;
  localparam int unsigned PW    = 2 * P;
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned CNT_W = $clog2(P + 1);

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_W);
  localparam logic signed [EW-1:0] BIAS     = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX    = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE    = EW'(1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [P-1:0]     hi_q, hi_d;
  logic [P-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic                 sa, sb, sr;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [P-1:0]         ma;
  logic [P:0]           sum;
  logic [PW-1:0]        prod, norm;
  logic                 msb, guard, sticky, rnd, carry;
  logic [MAN_W-1:0]     man_t;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] e_fin;
  logic [W-1:0]         res_n;
  logic [3:0]           flags_n;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (cnt_q == CNT_LAST) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_res   = res_q;
    out_flags = flags_q;
  end

  // ---------------------------------------------------------------- operand decode
  always_comb begin
    {sa, ea, fa} = a_q;
    {sb, eb, fb} = b_q;
    sr     = sa ^ sb;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    ma     = {|ea, fa};
  end

  // ---------------------------------------------------------------- normalise / round
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma} : '0);
    prod   = {hi_q, lo_q};
    msb    = prod[PW-1];
    norm   = msb ? prod : {prod[PW-2:0], 1'b0};
    man_t  = norm[PW-2:P];
    guard  = norm[P-1];
    sticky = |norm[P-2:0];
    rnd    = guard & (sticky | man_t[0]);
    man_r  = {1'b0, man_t} + (MAN_W+1)'(rnd);
    carry  = man_r[MAN_W];
    // carry-out leaves man_r[MAN_W-1:0] all zero, which is the renormalised mantissa
    e_fin  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
           + $signed({{(EW-1){1'b0}}, msb}) + $signed({{(EW-1){1'b0}}, carry});
  end

  always_comb begin
    res_n   = '0;
    flags_n = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_n[W-2 -: EXP_W] = '1;
      res_n[MAN_W-1]      = 1'b1;
      flags_n             = 4'b1000;
    end else if (a_inf || b_inf) begin
      res_n[W-1]          = sr;
      res_n[W-2 -: EXP_W] = '1;
      flags_n             = 4'b0100;
    end else if (a_zero || b_zero) begin
      res_n[W-1] = sr;
    end else if (e_fin >= E_MAX) begin
      res_n[W-1]          = sr;
      res_n[W-2 -: EXP_W] = '1;
      flags_n             = 4'b0110;
    end else if (e_fin < E_ONE) begin
      res_n[W-1] = sr;
      flags_n    = 4'b0001;
    end else begin
      res_n = {sr, e_fin[EXP_W-1:0], man_r[MAN_W-1:0]};
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          hi_d  = '0;
          lo_d  = {|in_b[W-2 -: EXP_W], in_b[MAN_W-1:0]};
          cnt_d = '0;
        end
      end
      MUL: begin
        // multiplier bits shift out of lo as product bits shift in from hi
        {hi_d, lo_d} = {sum, lo_q[P-1:1]};
        cnt_d        = cnt_q + 1'b1;
      end
      NORM: begin
        res_d   = res_n;
        flags_d = flags_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpm_seq.sv
// Self-checking bench for fpm_seq: single- and half-style instances, directed
// cases plus random operands against an arithmetic reference model.
module tb_fpm_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0;
  logic [31:0] a0, b0, r0;
  logic [3:0]  f0;
  logic        iv1, ir1, ov1, or1;
  logic [15:0] a1, b1, r1;
  logic [3:0]  f1;

  int total = 0;
  int bad   = 0;

  fpm_seq dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_a(a0), .in_b(b0),
    .out_valid(ov0), .out_ready(or0), .out_res(r0), .out_flags(f0)
  );

  fpm_seq #(.EXP_W(5), .MAN_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
    .out_valid(ov1), .out_ready(or1), .out_res(r1), .out_flags(f1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int m, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (m == 0) begin
      iv0 = v; a0 = a; b0 = b;
    end else begin
      iv1 = v; a1 = a[15:0]; b1 = b[15:0];
    end
  endtask

  task automatic set_ordy(input int m, input logic v);
    if (m == 0) or0 = v;
    else        or1 = v;
  endtask

  function automatic logic get_ov(input int m);
    return (m == 0) ? ov0 : ov1;
  endfunction

  function automatic logic get_ir(input int m);
    return (m == 0) ? ir0 : ir1;
  endfunction

  function automatic logic [31:0] get_res(input int m);
    return (m == 0) ? r0 : {16'h0000, r1};
  endfunction

  function automatic logic [3:0] get_flags(input int m);
    return (m == 0) ? f0 : f1;
  endfunction

  // Reference: exact integer product, rounded by comparing the discarded remainder to one half.
  function automatic void model(input int ew, input int mw, input longint unsigned a,
                                input longint unsigned b, output longint unsigned r,
                                output logic [3:0] f);
    longint unsigned one, mmask, ma, mb, prod, q, rem, half, sgn;
    int emax, bias, ea, eb, ex, sh;
    bit an, bn, ai, bi, az, bz, big;
    one   = 1;
    mmask = (one << mw) - 1;
    emax  = (1 << ew) - 1;
    bias  = (1 << (ew - 1)) - 1;
    ea    = int'((a >> mw) % (one << ew));
    eb    = int'((b >> mw) % (one << ew));
    sgn   = (((a >> (ew + mw)) ^ (b >> (ew + mw))) & one) << (ew + mw);
    an = (ea == emax) && ((a & mmask) != 0);
    bn = (eb == emax) && ((b & mmask) != 0);
    ai = (ea == emax) && ((a & mmask) == 0);
    bi = (eb == emax) && ((b & mmask) == 0);
    az = (ea == 0);
    bz = (eb == 0);
    f = 4'b0000;
    r = 0;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = (longint'(emax) << mw) | (one << (mw - 1));
      f = 4'b1000;
    end else if (ai || bi) begin
      r = sgn | (longint'(emax) << mw);
      f = 4'b0100;
    end else if (az || bz) begin
      r = sgn;
    end else begin
      ma   = (a & mmask) | (one << mw);
      mb   = (b & mmask) | (one << mw);
      prod = ma * mb;
      big  = prod >= (one << (2 * mw + 1));
      sh   = big ? mw + 1 : mw;
      q    = prod >> sh;
      rem  = prod & ((one << sh) - 1);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      ex = ea + eb - bias + int'(big);
      if (q == (one << (mw + 1))) begin
        q = q >> 1;
        ex++;
      end
      if (ex >= emax) begin
        r = sgn | (longint'(emax) << mw);
        f = 4'b0110;
      end else if (ex <= 0) begin
        r = sgn;
        f = 4'b0001;
      end else begin
        r = sgn | (longint'(ex) << mw) | (q & mmask);
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp(input int ew, input int mw);
    longint unsigned v;
    int emax, bias, k, e, sel;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    k    = bias / 2;
    sel  = int'($urandom_range(0, 9));
    if (sel == 0)      e = 0;
    else if (sel == 1) e = emax;
    else if (sel == 2) e = int'($urandom_range(1, emax - 1));
    else               e = bias - k + int'($urandom_range(0, 2 * k));
    v = (longint'($urandom_range(0, 1)) << (ew + mw)) | (longint'(e) << mw)
      | (longint'($urandom) & ((longint'(1) << mw) - 1));
    if (sel == 9) v = v & ~((longint'(1) << mw) - 1);
    return 32'(v);
  endfunction

  // One full transaction: accept, latency, result, optional back-pressure, release.
  task automatic run_op(input int m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef,
                        input int hold, input bit early);
    int n;
    int mw;
    mw = (m == 0) ? 23 : 10;
    n  = 0;
    while (!get_ir(m) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 32'(get_ir(m)), 32'd1);
    set_in(m, 1'b1, a, b);
    set_ordy(m, early);
    @(posedge clk); #1;
    set_in(m, 1'b0, $urandom, $urandom);
    n = 1;
    while (!get_ov(m) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(mw + 3));
    check("result", get_res(m), er);
    check("flags", 32'(get_flags(m)), 32'(ef));
    check("busy_ready", 32'(get_ir(m)), 32'd0);
    if (hold > 0) begin
      set_ordy(m, 1'b0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(get_ov(m)), 32'd1);
        check("hold_result", get_res(m), er);
        check("hold_ready", 32'(get_ir(m)), 32'd0);
      end
    end
    set_ordy(m, 1'b1);
    @(posedge clk); #1;
    check("release_valid", 32'(get_ov(m)), 32'd0);
    check("release_ready", 32'(get_ir(m)), 32'd1);
    set_ordy(m, 1'b0);
  endtask

  initial begin
    longint unsigned rr;
    logic [3:0]      rf;
    logic [31:0]     ra, rb;
    int              n;

    set_in(0, 1'b0, 32'h0, 32'h0);
    set_in(1, 1'b0, 32'h0, 32'h0);
    or0 = 1'b0;
    or1 = 1'b0;
    #2;
    check("reset_ready0", 32'(ir0), 32'd1);
    check("reset_valid0", 32'(ov0), 32'd0);
    check("reset_res0", r0, 32'h0);
    check("reset_flags0", 32'(f0), 32'h0);
    check("reset_ready1", 32'(ir1), 32'd1);
    check("reset_valid1", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single precision directed cases; first one also exercises back-pressure
    run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 10, 1'b0);
    run_op(0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 0, 1'b0);
    run_op(0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0000, 0, 1'b0);
    run_op(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000, 0, 1'b0);
    run_op(0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0110, 0, 1'b0);
    run_op(0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 0, 1'b0);
    run_op(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0, 1'b0);
    run_op(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0100, 0, 1'b0);
    run_op(0, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0, 1'b0);
    run_op(0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b1000, 0, 1'b1);

    // reduced-width instance directed cases
    run_op(1, 32'h3E00, 32'h4000, 32'h4200, 4'b0000, 3, 1'b0);
    run_op(1, 32'h3C01, 32'h3E00, 32'h3E02, 4'b0000, 0, 1'b0);
    run_op(1, 32'h7800, 32'h4000, 32'h7C00, 4'b0110, 0, 1'b0);
    run_op(1, 32'h0400, 32'h0400, 32'h0000, 4'b0001, 0, 1'b0);
    run_op(1, 32'h7C00, 32'h0000, 32'h7E00, 4'b1000, 0, 1'b0);
    run_op(1, 32'hFC00, 32'h4000, 32'hFC00, 4'b0100, 0, 1'b0);

    // reset in the middle of the multiply phase
    set_in(0, 1'b1, 32'h3FC00000, 32'h40000000);
    @(posedge clk); #1;
    set_in(0, 1'b0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(ov0), 32'd0);
    check("midrst_ready", 32'(ir0), 32'd1);
    check("midrst_res", r0, 32'h0);
    check("midrst_flags", 32'(f0), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ov0) n++;
    end
    check("no_stale_result", 32'(n), 32'd0);
    run_op(0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 0, 1'b0);

    // random operands against the reference model, both instances
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        ra = (m == 0) ? rand_fp(8, 23) : rand_fp(5, 10);
        rb = (m == 0) ? rand_fp(8, 23) : rand_fp(5, 10);
        if (m == 0) model(8, 23, longint'(ra), longint'(rb), rr, rf);
        else        model(5, 10, longint'(ra), longint'(rb), rr, rf);
        run_op(m, ra, rb, 32'(rr), rf, (i % 5 == 0) ? 2 : 0, bit'(i % 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
